next_pc_sequencer: RTL
======================

NEXT_PC_SEQUENCER -- requirements
Module: next_pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Parameter TRAP_VECTOR, default 32'h0000_0100, is the PC value loaded on a misaligned-target trap.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset, with ports as follows:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- imem_ready  in  1  instruction memory has returned the instruction at imem_addr.
- exec_done  in  1  datapath has finished the current instruction.
- stall  in  1  hold the current instruction; exec_done is ignored.
- branch  in  1  current instruction is a conditional branch.
- zero  in  1  ALU zero flag.
- jump  in  1  current instruction is JAL/JALR.
- branch_target  in  32  branch destination address.
- jump_target  in  32  jump destination address.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; equals pc.
- instr_valid  out  1  fetched instruction is valid for execution.
- pc  out  32  current program counter.
- pc_plus4  out  32  pc + 4, modulo 2^32.
- trap  out  1  one-cycle misaligned-target pulse.
- bad_addr  out  32  last misaligned target.
- retired_count  out  32  instructions retired.

Function
REQ-004 The FSM SHALL have exactly three states, IDLE, FETCH and EXEC, and SHALL enter IDLE on reset.
REQ-005 IDLE SHALL transition to FETCH unconditionally on the next clock edge.
REQ-006 In FETCH, imem_req SHALL be 1; on imem_ready=1 the FSM SHALL move to EXEC, otherwise it SHALL remain in FETCH.
REQ-007 instr_valid SHALL be 1 only in EXEC, and imem_req SHALL be 0 outside FETCH.
REQ-008 In EXEC, an instruction is accepted when exec_done=1 and stall=0.
- stall=1 holds EXEC and all registers.
- Without acceptance, EXEC is held.
REQ-009 On acceptance, the next-PC source SHALL be selected by fixed priority:
- jump=1 selects jump_target;
- otherwise (branch & zero)=1 selects branch_target;
- otherwise pc_plus4 is selected.
REQ-010 If the selected target has bits [1:0] != 2'b00, the block SHALL, on the accepting edge:
- load pc with TRAP_VECTOR;
- load bad_addr with the target;
- pulse trap for the following cycle;
- leave retired_count unchanged.
REQ-011 Otherwise, on the accepting edge, pc SHALL load the selected value and retired_count SHALL increment by 1.
REQ-012 After acceptance, the FSM SHALL always go to FETCH, so the new pc is visible one cycle after the accepting edge.
REQ-013 pc_plus4 SHALL be combinational from pc; pc=32'hFFFF_FFFC gives pc_plus4=32'h0000_0000.
REQ-014 retired_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-015 trap SHALL be 1 for exactly one cycle per trap event, and bad_addr SHALL hold its value until the next trap.
REQ-016 Inputs other than rst SHALL have no effect in IDLE, and branch, jump, zero and the targets SHALL have no effect in FETCH.

Reset
REQ-017 While rst=1, asynchronously and regardless of the clock, the block SHALL hold:
- state=IDLE, pc=RESET_VECTOR;
- bad_addr=0, retired_count=0;
- trap=0, imem_req=0, instr_valid=0.
REQ-018 Reset asserted mid-FETCH or mid-EXEC SHALL abort the instruction with no pc or retired_count update.

Verification
REQ-019 Sequential fetch: release reset, imem_ready=1 in FETCH, exec_done=1 with branch=jump=0 -> pc steps 0x0, 0x4, 0x8; retired_count=3 after 3 acceptances.
REQ-020 Taken/not-taken branch: branch=1, zero=1, branch_target=0x40 -> pc=0x40; repeat with zero=0 -> pc=0x44.
REQ-021 Priority and misaligned target: jump=1, jump_target=0x80, with branch=1, zero=1, branch_target=0x40 -> pc=0x80; then jump_target=0x82 -> pc=0x100, trap=1 for one cycle, bad_addr=0x82, retired_count unchanged.
REQ-022 Stall and wait: exec_done=1 with stall=1 for 3 cycles -> pc and retired_count hold; imem_ready=0 for 4 cycles -> FSM stays in FETCH with imem_req=1.
REQ-023 Boundaries: force pc=0xFFFFFFFC via jump_target and accept with no branch or jump -> pc=0x0; assert rst mid-EXEC -> pc=RESET_VECTOR and retired_count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/next_pc_sequencer_if.sv
// Fetch/execute handshake and next-PC bus between the sequencer and its datapath.
// The master drives fetch/execute status and branch/jump info; the slave drives the PC state.
interface next_pc_sequencer_if;
    logic        imem_ready;
    logic        exec_done;
    logic        stall;
    logic        branch;
    logic        zero;
    logic        jump;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        trap;
    logic [31:0] bad_addr;
    logic [31:0] retired_count;

    modport master (
        output imem_ready, exec_done, stall, branch, zero, jump,
               branch_target, jump_target,
        input  imem_req, imem_addr, instr_valid, pc, pc_plus4,
               trap, bad_addr, retired_count
    );

    modport slave (
        input  imem_ready, exec_done, stall, branch, zero, jump,
               branch_target, jump_target,
        output imem_req, imem_addr, instr_valid, pc, pc_plus4,
               trap, bad_addr, retired_count
    );
endinterface

// File: rtl/next_pc_sequencer.sv
// Three-state fetch/execute sequencer holding the PC. It selects the next PC
// (jump > taken branch > pc+4) and traps to TRAP_VECTOR on a misaligned target.
module next_pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic                  clk,
    input  logic                  rst,
    next_pc_sequencer_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_bad_addr;
    logic [31:0] r_retired;
    logic        r_trap;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;
    logic        w_accept;
    logic        w_misalign;

    assign w_pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // stall overrides exec_done, so a stalled EXEC simply waits.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE:    w_state_nxt = FETCH;
            FETCH:   if (bus.imem_ready) w_state_nxt = EXEC;
            EXEC: begin
                if (bus.exec_done && !bus.stall) begin
                    w_accept    = 1'b1;
                    w_state_nxt = FETCH;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_target = w_pc_plus4;
        if (bus.jump)                     w_target = bus.jump_target;
        else if (bus.branch && bus.zero)  w_target = bus.branch_target;
    end

    assign w_misalign = |w_target[1:0];

    // A misaligned target replaces the retire with a trap; the count is left alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_VECTOR;
            r_bad_addr <= 32'd0;
            r_retired  <= 32'd0;
            r_trap     <= 1'b0;
        end else begin
            r_trap <= 1'b0;
            if (w_accept) begin
                if (w_misalign) begin
                    r_pc       <= TRAP_VECTOR;
                    r_bad_addr <= w_target;
                    r_trap     <= 1'b1;
                end else begin
                    r_pc      <= w_target;
                    r_retired <= r_retired + 32'd1;
                end
            end
        end
    end

    assign bus.imem_req      = (r_state == FETCH);
    assign bus.instr_valid   = (r_state == EXEC);
    assign bus.imem_addr     = r_pc;
    assign bus.pc            = r_pc;
    assign bus.pc_plus4      = w_pc_plus4;
    assign bus.trap          = r_trap;
    assign bus.bad_addr      = r_bad_addr;
    assign bus.retired_count = r_retired;
endmodule
